// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard, stall and flush controller for the in-order pipeline.
// Drives the IF/ID select, PC enable, ID/EX bubble and EX hold; counts events.
module pipe_ctrl #(
    parameter int IMEM_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             ex_mdu_busy,
    input  logic             imem_ready,
    output logic [1:0]       instr_sel,
    output logic             load_use,
    output logic             pc_write,
    output logic             idex_bubble,
    output logic             ex_hold,
    output logic             fetch_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        REPLAY = 2'b01,
        FLUSH  = 2'b10,
        WAIT   = 2'b11
    } state_t;

    localparam int WW = $clog2(IMEM_TIMEOUT + 1);

    state_t           cur;
    state_t           nxt;
    logic [WW-1:0]    wait_cnt;
    logic [WW-1:0]    wait_nxt;
    logic             held;
    logic             hazard;
    logic             ferr;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        instr_sel   = 2'b00;
        pc_write    = 1'b1;
        load_use    = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        nxt         = cur;
        if (ex_redirect) begin
            instr_sel   = 2'b10;
            idex_bubble = 1'b1;
            nxt         = FLUSH;
        end else if (ex_mdu_busy) begin
            pc_write  = 1'b0;
            load_use  = 1'b1;
            ex_hold   = 1'b1;
            instr_sel = (cur == REPLAY || held) ? 2'b01 : 2'b00;
        end else begin
            unique case (cur)
                FLUSH: begin
                    idex_bubble = 1'b1;
                    nxt         = RUN;
                end
                REPLAY: begin
                    instr_sel = 2'b01;
                    nxt       = RUN;
                end
                default: begin
                    if (cur == RUN && hazard) begin
                        load_use    = 1'b1;
                        pc_write    = 1'b0;
                        idex_bubble = 1'b1;
                        nxt         = REPLAY;
                    end else if (!imem_ready) begin
                        instr_sel = 2'b10;
                        pc_write  = 1'b0;
                        load_use  = 1'b1;
                        nxt       = WAIT;
                    end else begin
                        nxt = RUN;
                    end
                end
            endcase
        end
        // Reset forces the idle RUN outputs regardless of the pipeline inputs.
        if (!rst) begin
            instr_sel   = 2'b00;
            pc_write    = 1'b1;
            load_use    = 1'b0;
            idex_bubble = 1'b0;
            ex_hold     = 1'b0;
            nxt         = RUN;
        end
    end

    // The cycle that enters WAIT counts as the first imem-low cycle.
    always_comb begin
        wait_nxt = '0;
        if (nxt == WAIT) begin
            if (wait_cnt == WW'(IMEM_TIMEOUT))
                wait_nxt = wait_cnt;
            else
                wait_nxt = wait_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur      <= RUN;
            wait_cnt <= '0;
            ferr     <= 1'b0;
            held     <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            cur      <= nxt;
            wait_cnt <= wait_nxt;
            held     <= load_use;
            if (wait_nxt == WW'(IMEM_TIMEOUT))
                ferr <= 1'b1;
            if (!pc_write && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (ex_redirect && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign state     = cur;
    assign fetch_err = ferr;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus for pipe_ctrl, checked by a
// scoreboard fed from a behavioural model of the stall/flush rules.
module tb_pipe_ctrl;

    localparam int TO  = 15;
    localparam int CW  = 6;
    localparam int MAX = (1 << CW) - 1;

    typedef struct packed {
        logic       rstn;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       busy;
        logic       ready;
    } stim_t;

    typedef struct packed {
        logic [1:0]    isel;
        logic          lu;
        logic          pcw;
        logic          bub;
        logic          hold;
        logic          err;
        logic [1:0]    st;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    id_rs1 = '0;
    logic [4:0]    id_rs2 = '0;
    logic          id_use_rs1 = 1'b0;
    logic          id_use_rs2 = 1'b0;
    logic [4:0]    ex_rd = '0;
    logic          ex_mem_read = 1'b0;
    logic          ex_redirect = 1'b0;
    logic          ex_mdu_busy = 1'b0;
    logic          imem_ready = 1'b1;
    logic [1:0]    instr_sel;
    logic          load_use;
    logic          pc_write;
    logic          idex_bubble;
    logic          ex_hold;
    logic          fetch_err;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic [1:0]    state;

    pipe_ctrl #(.IMEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect), .ex_mdu_busy(ex_mdu_busy),
        .imem_ready(imem_ready),
        .instr_sel(instr_sel), .load_use(load_use), .pc_write(pc_write),
        .idex_bubble(idex_bubble), .ex_hold(ex_hold),
        .fetch_err(fetch_err), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .state(state)
    );

    always #5 clk = ~clk;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;

    // Model state: the pending stall mode plus plain integer counters.
    int m_mode = 0;
    int m_wait = 0;
    int m_err = 0;
    int m_stall = 0;
    int m_flush = 0;
    int m_held = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rstn = 1'b1;
        s.ready = 1'b1;
        return s;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        int   nx;
        bit   hz;
        hz = s.mr && s.rd != 0 &&
             ((s.u1 && s.r1 == s.rd) || (s.u2 && s.r2 == s.rd));
        e = '0;
        e.pcw = 1'b1;
        if (!s.rstn) begin
            m_mode = 0; m_wait = 0; m_err = 0;
            m_stall = 0; m_flush = 0; m_held = 0;
            return e;
        end
        e.st  = 2'(m_mode);
        e.err = m_err[0];
        e.sc  = CW'(m_stall);
        e.fc  = CW'(m_flush);
        nx = m_mode;
        if (s.redir) begin
            e.isel = 2'd2; e.bub = 1'b1; nx = 2;
        end else if (s.busy) begin
            e.pcw = 1'b0; e.lu = 1'b1; e.hold = 1'b1;
            e.isel = (m_mode == 1 || m_held != 0) ? 2'd1 : 2'd0;
        end else if (m_mode == 2) begin
            e.bub = 1'b1; nx = 0;
        end else if (m_mode == 1) begin
            e.isel = 2'd1; nx = 0;
        end else if (m_mode == 0 && hz) begin
            e.lu = 1'b1; e.pcw = 1'b0; e.bub = 1'b1; nx = 1;
        end else if (!s.ready) begin
            e.isel = 2'd2; e.pcw = 1'b0; e.lu = 1'b1; nx = 3;
        end else begin
            nx = 0;
        end
        m_stall = sat(m_stall + (e.pcw ? 0 : 1), MAX);
        m_flush = sat(m_flush + (s.redir ? 1 : 0), MAX);
        m_wait  = (nx == 3) ? sat(m_wait + 1, TO) : 0;
        if (m_wait >= TO) m_err = 1;
        m_held = e.lu ? 1 : 0;
        m_mode = nx;
        return e;
    endfunction

    task automatic cyc(input stim_t s);
        @(posedge clk);
        #1;
        rst         = s.rstn;
        id_rs1      = s.r1;
        id_rs2      = s.r2;
        id_use_rs1  = s.u1;
        id_use_rs2  = s.u2;
        ex_rd       = s.rd;
        ex_mem_read = s.mr;
        ex_redirect = s.redir;
        ex_mdu_busy = s.busy;
        imem_ready  = s.ready;
        sbq.push_back(model(s));
    endtask

    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                got = {instr_sel, load_use, pc_write, idex_bubble, ex_hold,
                       fetch_err, state, stall_cnt, flush_cnt};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL cyc%0d got=%h exp=%h", ncyc, got, e);
                end
                ncyc++;
            end
        end
    end

    initial begin : driver
        stim_t s;
        int    drought;
        #1 rst = 1'b0;
        s = idle(); s.rstn = 1'b0;
        cyc(s); cyc(s);
        // load-use on rs1, then the replay cycle
        s = idle(); s.mr = 1; s.rd = 5'd5; s.r1 = 5'd5; s.u1 = 1;
        cyc(s);
        cyc(idle()); cyc(idle());
        // no hazard through x0 or an unused source
        s = idle(); s.mr = 1; s.rd = 5'd0; s.r1 = 5'd0; s.u1 = 1;
        cyc(s);
        s = idle(); s.mr = 1; s.rd = 5'd5; s.r1 = 5'd5; s.u1 = 0;
        cyc(s);
        s = idle(); s.mr = 1; s.rd = 5'd7; s.r2 = 5'd7; s.u2 = 1;
        cyc(s); cyc(idle());
        // single redirect pulse
        s = idle(); s.redir = 1;
        cyc(s); cyc(idle()); cyc(idle());
        // redirect wins over a simultaneous hazard
        s = idle(); s.redir = 1; s.mr = 1; s.rd = 5'd9; s.r1 = 5'd9; s.u1 = 1;
        cyc(s); cyc(idle()); cyc(idle());
        // fetch timeout
        s = idle(); s.ready = 0;
        for (int i = 0; i < TO; i++) cyc(s);
        cyc(idle()); cyc(idle()); cyc(idle());
        // mdu busy during replay
        s = idle(); s.mr = 1; s.rd = 5'd3; s.r1 = 5'd3; s.u1 = 1;
        cyc(s);
        s = idle(); s.busy = 1;
        for (int i = 0; i < 4; i++) cyc(s);
        cyc(idle()); cyc(idle());
        // reset mid-wait
        s = idle(); s.ready = 0;
        cyc(s); cyc(s); cyc(s);
        s = idle(); s.rstn = 0;
        cyc(s);
        cyc(idle()); cyc(idle());
        // random traffic with occasional long fetch droughts
        drought = 0;
        for (int i = 0; i < 1500; i++) begin
            s = idle();
            s.rstn  = ($urandom_range(0, 199) != 0);
            s.rd    = 5'($urandom_range(0, 3));
            s.r1    = 5'($urandom_range(0, 3));
            s.r2    = 5'($urandom_range(0, 3));
            s.u1    = 1'($urandom_range(0, 1));
            s.u2    = 1'($urandom_range(0, 1));
            s.mr    = ($urandom_range(0, 2) == 0);
            s.redir = ($urandom_range(0, 9) == 0);
            s.busy  = ($urandom_range(0, 7) == 0);
            if (drought == 0 && $urandom_range(0, 59) == 0)
                drought = $urandom_range(10, 20);
            if (drought > 0) begin
                s.ready = 1'b0;
                s.redir = 1'b0;
                drought--;
            end else begin
                s.ready = ($urandom_range(0, 5) != 0);
            end
            cyc(s);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
